mux_nto1_scan: RTL

Parametrised N-channel, W-bit multiplexer with a registered output and two selection modes: manual (external `sel`) and auto-scan (internal channel rotation with a programmable dwell time and a channel-enable mask). It generalises the 4-to-1 single-bit multiplexer to arbitrary channel count and width. It sits in front of shared single-channel consumers (display, serial out, probe) that must time-multiplex several sources.

---
 rtl/mux_nto1_scan_if.sv | 34 +++
 rtl/mux_nto1_scan.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nto1_scan_if
//  Description : Bus bundle for mux_nto1_scan. Carries the packed channel
//                data, selection controls and the registered results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_nto1_scan_if #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N)
);
    logic [N*W-1:0]   in;
    logic [SEL_W-1:0] sel;
    logic             mode;
    logic [N-1:0]     en_mask;
    logic [W-1:0]     out;
    logic [SEL_W-1:0] cur_sel;
    logic             out_valid;
    logic             wrap;

    // Source side: drives data and selection, observes the muxed result.
    modport master (
        output in, sel, mode, en_mask,
        input  out, cur_sel, out_valid, wrap
    );

    // Multiplexer side.
    modport slave (
        input  in, sel, mode, en_mask,
        output out, cur_sel, out_valid, wrap
    );
endinterface
`default_nettype wire

// File: rtl/mux_nto1_scan.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nto1_scan
//  Description : N-channel, W-bit multiplexer with registered output.
//                Manual mode follows the external select; scan mode rotates
//                through the enabled channels, dwelling HOLD cycles on each.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1_scan #(
    parameter int N    = 4,
    parameter int W    = 1,
    parameter int HOLD = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    mux_nto1_scan_if.slave  bus
);
    localparam int SEL_W = $clog2(N);
    localparam int HC_W  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HC_W-1:0] c_HOLD_LAST = HC_W'(HOLD - 1);

    // Operating mode is a pure decode of the inputs; nothing stores it.
    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    state_t           w_state;

    logic [SEL_W-1:0] r_cur_sel;
    logic [HC_W-1:0]  r_hold_cnt;
    logic [W-1:0]     r_out;
    logic             r_out_valid;
    logic             r_wrap;

    logic [SEL_W-1:0] w_cur_sel_nxt;
    logic [HC_W-1:0]  w_hold_cnt_nxt;
    logic [W-1:0]     w_out_nxt;
    logic             w_out_valid_nxt;
    logic             w_wrap_nxt;

    logic [W-1:0]     w_ch [N];
    logic [W-1:0]     w_man_data;
    logic             w_man_ok;
    logic [W-1:0]     w_scan_data;
    logic             w_cur_en;
    logic             w_hi_found;
    logic [SEL_W-1:0] w_hi_idx;
    logic [SEL_W-1:0] w_lo_idx;

    generate
        for (genvar k = 0; k < N; k++) begin : g_unpack
            assign w_ch[k] = bus.in[k*W +: W];
        end
    endgenerate

    // Channel reads for the manual select and the scan index; an index
    // beyond N-1 reads as zero and as a disabled channel.
    always_comb begin
        w_man_data  = '0;
        w_scan_data = '0;
        w_cur_en    = 1'b0;
        w_man_ok    = (int'(bus.sel) < N);
        for (int k = 0; k < N; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                w_man_data = w_ch[k];
            end
            if (r_cur_sel == SEL_W'(k)) begin
                w_scan_data = w_ch[k];
                w_cur_en    = bus.en_mask[k];
            end
        end
    end

    // Next enabled channel: lowest set index above the current one, else
    // the lowest set index overall (which is the wrap case).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.en_mask[k]) begin
                w_lo_idx = SEL_W'(k);
                if (k > int'(r_cur_sel)) begin
                    w_hi_idx   = SEL_W'(k);
                    w_hi_found = 1'b1;
                end
            end
        end
    end

    // Mode decode and next values for every registered output.
    always_comb begin
        w_cur_sel_nxt   = r_cur_sel;
        w_hold_cnt_nxt  = '0;
        w_out_nxt       = '0;
        w_out_valid_nxt = 1'b0;
        w_wrap_nxt      = 1'b0;

        if (!bus.mode) begin
            w_state = ST_MANUAL;
        end else if (|bus.en_mask) begin
            w_state = ST_SCAN;
        end else begin
            w_state = ST_STALL;
        end

        case (w_state)
            ST_MANUAL: begin
                w_cur_sel_nxt = bus.sel;
                if (w_man_ok) begin
                    w_out_nxt       = w_man_data;
                    w_out_valid_nxt = 1'b1;
                end
            end
            ST_SCAN: begin
                w_out_valid_nxt = w_cur_en;
                w_out_nxt       = w_cur_en ? w_scan_data : '0;
                // A disabled current channel is skipped immediately rather
                // than waiting out its dwell.
                if ((r_hold_cnt == c_HOLD_LAST) || !w_cur_en) begin
                    w_hold_cnt_nxt = '0;
                    if (w_hi_found) begin
                        w_cur_sel_nxt = w_hi_idx;
                    end else begin
                        w_cur_sel_nxt = w_lo_idx;
                        w_wrap_nxt    = 1'b1;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                // Stall: index frozen, output forced invalid.
            end
        endcase
    end

    // Output and scan-position registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_sel   <= '0;
            r_hold_cnt  <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_cur_sel   <= w_cur_sel_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_wrap      <= w_wrap_nxt;
        end
    end

    assign bus.out       = r_out;
    assign bus.cur_sel   = r_cur_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.wrap      = r_wrap;

endmodule
`default_nettype wire
